// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the data-memory responder and its RAM array.
`ifndef WORD
`define WORD 32
`endif

package cpu_pkg;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_WAIT,
        DM_RESP
    } dmem_state_t;

    localparam int BYTES_PER_WORD = `WORD / 8;

    // An access is bad when it is not word aligned, or when it addresses
    // beyond the 2**power words backing the RAM.
    function automatic logic addr_err(input logic [`WORD-1:0] addr, input int power);
        logic [`WORD-1:0] hi;
        hi = addr >> (power + 2);
        return (addr[1:0] != 2'b00) || (hi != '0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Data RAM: synchronous byte-enabled write, asynchronous word read.
module dmem_array
    import cpu_pkg::*;
#(
    parameter int DMEM_POWER = 18
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [BYTES_PER_WORD-1:0] be,
    input  logic [DMEM_POWER-1:0]     idx,
    input  logic [`WORD-1:0]          wdata,
    output logic [`WORD-1:0]          rdata
);

    logic [`WORD-1:0] mem [2**DMEM_POWER];

    // Write only the enabled byte lanes; the other lanes keep their contents
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (we && be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory slave. Accepts one load/store at a time over a
// valid/ready request channel and answers LATENCY cycles later on a
// valid/ready response channel. Stores commit to RAM at acceptance; loads
// read at acceptance and the word is held until the response is taken.
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int DMEM_POWER = 18,
    parameter int LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reqValid,
    output logic                      reqReady,
    input  logic                      reqWrite,
    input  logic [`WORD-1:0]          reqAddr,
    input  logic [`WORD-1:0]          reqWData,
    input  logic [BYTES_PER_WORD-1:0] reqByteEn,
    output logic                      rspValid,
    input  logic                      rspReady,
    output logic [`WORD-1:0]          rspData,
    output logic                      rspErr
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    dmem_state_t      state;
    dmem_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [`WORD-1:0] rsp_data_q;
    logic             rsp_err_q;
    logic             accept;
    logic             req_err;
    logic             ram_we;
    logic [`WORD-1:0] ram_rdata;

    // A request is taken only in IDLE and never while reset is asserted,
    // so a store presented during reset cannot reach the RAM.
    assign accept  = reqValid && reqReady && !reset;
    assign req_err = addr_err(reqAddr, DMEM_POWER);
    assign ram_we  = accept && reqWrite && !req_err;

    dmem_array #(
        .DMEM_POWER(DMEM_POWER)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .be    (reqByteEn),
        .idx   (reqAddr[DMEM_POWER+1:2]),
        .wdata (reqWData),
        .rdata (ram_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            DM_IDLE: begin
                if (reqValid) begin
                    state_next = (LATENCY == 1) ? DM_RESP : DM_WAIT;
                end
            end
            DM_WAIT: begin
                if (cnt <= CNT_W'(1)) begin
                    state_next = DM_RESP;
                end
            end
            DM_RESP: begin
                if (rspReady) begin
                    state_next = DM_IDLE;
                end
            end
            default: state_next = DM_IDLE;
        endcase
    end

    // Handshake outputs follow the state directly
    always_comb begin
        reqReady = (state == DM_IDLE);
        rspValid = (state == DM_RESP);
    end

    // Latency counter and response register, loaded at acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (accept) begin
            cnt        <= CNT_W'(LATENCY - 1);
            rsp_data_q <= (reqWrite || req_err) ? '0 : ram_rdata;
            rsp_err_q  <= req_err;
        end else if (state == DM_WAIT && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign rspData = rsp_data_q;
    assign rspErr  = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances cover LATENCY 2, 4 and 1.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_data  [3];
    logic        rsp_err   [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DMEM_POWER(g == 0 ? 18 : 10),
            .LATENCY   (g == 0 ? 2 : (g == 1 ? 4 : 1))
        ) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .reqValid  (req_valid[g]),
            .reqReady  (req_ready[g]),
            .reqWrite  (req_write[g]),
            .reqAddr   (req_addr[g]),
            .reqWData  (req_wdata[g]),
            .reqByteEn (req_be[g]),
            .rspValid  (rsp_valid[g]),
            .rspReady  (rsp_ready[g]),
            .rspData   (rsp_data[g]),
            .rspErr    (rsp_err[g])
        );
    end

    function automatic int lat_of(input int u);
        case (u)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    // One full request/response with rspReady held high.
    task automatic transact(input int u, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be,
                            input logic [31:0] exp_d, input logic exp_e,
                            input string nm);
        int k;
        total++;
        if (req_ready[u] !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_idle: got %b want 1", nm, req_ready[u]);
        end
        rsp_ready[u] = 1'b1;
        req_valid[u] = 1'b1;
        req_write[u] = w;
        req_addr[u]  = a;
        req_wdata[u] = d;
        req_be[u]    = be;
        @(posedge clk); #1;
        req_valid[u] = 1'b0;
        req_write[u] = ~w;
        req_addr[u]  = a ^ 32'h4;
        req_wdata[u] = ~d;
        req_be[u]    = ~be;
        k = 0;
        while (rsp_valid[u] !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (k != lat_of(u) - 1) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", nm, k + 1, lat_of(u));
        end
        total++;
        if (rsp_data[u] !== exp_d) begin
            bad++;
            $display("FAIL %s data: got %h want %h", nm, rsp_data[u], exp_d);
        end
        total++;
        if (rsp_err[u] !== exp_e) begin
            bad++;
            $display("FAIL %s err: got %b want %b", nm, rsp_err[u], exp_e);
        end
        total++;
        if (req_ready[u] !== 1'b0) begin
            bad++;
            $display("FAIL %s ready_in_resp: got %b want 0", nm, req_ready[u]);
        end
        @(posedge clk); #1;
        total++;
        if (rsp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
            bad++;
            $display("FAIL %s after_handshake: got valid=%b ready=%b want valid=0 ready=1",
                     nm, rsp_valid[u], req_ready[u]);
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1;
            req_valid[u] = 1'b0;
            req_write[u] = 1'b0;
            req_addr[u] = '0;
            req_wdata[u] = '0;
            req_be[u] = '0;
            rsp_ready[u] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        for (int u = 0; u < 3; u++) begin
            total++;
            if (req_ready[u] !== 1'b1 || rsp_valid[u] !== 1'b0 ||
                rsp_data[u] !== 32'h0 || rsp_err[u] !== 1'b0) begin
                bad++;
                $display("FAIL reset_u%0d: got ready=%b valid=%b data=%h err=%b want 1 0 0 0",
                         u, req_ready[u], rsp_valid[u], rsp_data[u], rsp_err[u]);
            end
        end
    endtask

    task automatic test_directed(input int u, input logic [31:0] oor);
        string p;
        p = $sformatf("u%0d", u);
        transact(u, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, {p, "_store_full"});
        transact(u, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, {p, "_load_full"});
        transact(u, 1'b1, 32'h100, 32'h11223344, 4'b0101, 32'h0, 1'b0, {p, "_store_part"});
        transact(u, 1'b0, 32'h100, 32'h0, 4'hF, 32'hDE22BE44, 1'b0, {p, "_load_part"});
        transact(u, 1'b1, 32'h102, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, {p, "_store_misal"});
        transact(u, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, {p, "_load_after_misal"});
        transact(u, 1'b0, 32'h101, 32'h0, 4'h0, 32'h0, 1'b1, {p, "_load_misal"});
        transact(u, 1'b0, oor, 32'h0, 4'h0, 32'h0, 1'b1, {p, "_load_oor"});
        transact(u, 1'b1, 32'h100, 32'h0, 4'h0, 32'h0, 1'b0, {p, "_store_be0"});
        transact(u, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, {p, "_load_after_be0"});
    endtask

    task automatic test_backpressure();
        int k;
        logic stable;
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h100;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        k = 0;
        while (rsp_valid[0] !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        // A competing store is offered during the stall and must be ignored.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h100;
        req_wdata[0] = 32'h55555555;
        req_be[0]    = 4'hF;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'hDE22BE44 ||
                rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
                stable = 1'b0;
                $display("FAIL bp_hold cycle %0d: got valid=%b data=%h err=%b ready=%b want 1 de22be44 0 0",
                         i, rsp_valid[0], rsp_data[0], rsp_err[0], req_ready[0]);
            end
            @(posedge clk); #1;
        end
        total++;
        if (!stable) bad++;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        total++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got valid=%b ready=%b want valid=0 ready=1",
                     rsp_valid[0], req_ready[0]);
        end
        transact(0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, "bp_no_stray_store");
    endtask

    task automatic test_reset_in_wait();
        logic quiet;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h200;
        req_wdata[1] = 32'hCAFEF00D;
        req_be[1]    = 4'hF;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
            bad++;
            $display("FAIL rst_wait_pre: got valid=%b ready=%b want 0 0", rsp_valid[1], req_ready[1]);
        end
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        total++;
        if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
            bad++;
            $display("FAIL rst_wait_post: got valid=%b ready=%b want 0 1", rsp_valid[1], req_ready[1]);
        end
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (rsp_valid[1] !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL rst_wait_abandon: got a response want none");
        end
        transact(1, 1'b0, 32'h200, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "rst_wait_load");
    endtask

    initial begin
        test_reset();
        test_directed(0, 32'h0010_0000);
        test_backpressure();
        test_reset_in_wait();
        test_directed(1, 32'h0000_1000);
        test_directed(2, 32'h0000_1000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
